// File: rtl/transpose_stream.sv
// transpose_stream: two-bank N x N block buffer with valid/ready on both sides.
// Each block is emitted column-major (transposed) or row-major, chosen by its first sample.
module transpose_stream #(
    parameter int DATA_W = 12,
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_transpose_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);
    localparam int LN = $clog2(N);
    localparam int L = 2 * LN;
    localparam logic [L-1:0] LAST = '1;
    logic [DATA_W-1:0] mem_q [2**(L+1)];
    logic              wb_q, rb_q;
    logic [L-1:0]      wi_q, ri_q, raddr;
    logic [1:0]        full_q, full_d, mode_q;
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic              wr, ld;
    assign in_ready_o  = !full_q[wb_q] && !rst;
    assign wr          = in_valid_i && in_ready_o;
    assign ld          = full_q[rb_q] && (!out_valid_q || out_ready_i);
    // column-major read swaps the row and column halves of the index
    assign raddr       = mode_q[rb_q] ? {ri_q[LN-1:0], ri_q[L-1:LN]} : ri_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    always_comb begin
        full_d = full_q;
        if (wr && wi_q == LAST) full_d[wb_q] = 1'b1;
        if (ld && ri_q == LAST) full_d[rb_q] = 1'b0;
    end
    always_ff @(posedge clk)
        if (wr) mem_q[{wb_q, wi_q}] <= in_data_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wi_q        <= '0;
            ri_q        <= '0;
            full_q      <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr) begin
                wi_q <= wi_q + 1'b1;
                if (wi_q == '0) mode_q[wb_q] <= in_transpose_i;
                if (wi_q == LAST) wb_q <= !wb_q;
            end
            if (ld) begin
                out_data_q  <= mem_q[{rb_q, raddr}];
                out_last_q  <= ri_q == LAST;
                out_valid_q <= 1'b1;
                ri_q        <= ri_q + 1'b1;
                if (ri_q == LAST) rb_q <= !rb_q;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_transpose_stream.sv
// tb_transpose_stream: directed checks on an 8x8/12-bit instance plus random
// traffic on 4x4/32-bit and 16x16/1-bit instances, all against a block-order model.
module tb_transpose_stream;
    logic clk = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen
        localparam int N  = g == 0 ? 8 : g == 1 ? 4 : 16;
        localparam int DW = g == 0 ? 12 : g == 1 ? 32 : 1;
        localparam int D  = N * N;
        localparam int NB = g == 1 ? 1000 : 60;
        logic          rst, in_valid, in_ready, in_t, out_valid, out_ready, out_last;
        logic [DW-1:0] in_data, out_data;
        logic [DW-1:0] blk[$], ed[$], got[$], pd;
        logic          el[$], gotl[$], blk_t, pl;
        int            gotc[$];
        bit            pv_hold = 0, stop = 0, fin = 0;
        int            ins = 0, outs = 0, lasts = 0;

        transpose_stream #(.DATA_W(DW), .N(N)) dut (
            .clk(clk), .rst(rst),
            .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_transpose_i(in_t),
            .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last)
        );

        // model: collect a whole block, then queue its samples in output order
        always @(negedge clk) begin
            if (rst) begin
                blk.delete();
                ed.delete();
                el.delete();
                pv_hold = 0;
            end else begin
                if (pv_hold) begin
                    chk("hold data", out_data, pd);
                    chk("hold last", out_last, pl);
                end
                pv_hold = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
                if (in_valid && in_ready) begin
                    if (blk.size() == 0) blk_t = in_t;
                    blk.push_back(in_data);
                    ins++;
                    if (blk.size() == D) begin
                        for (int k = 0; k < D; k++) begin
                            ed.push_back(blk[blk_t ? (k % N) * N + k / N : k]);
                            el.push_back(k == D - 1);
                        end
                        blk.delete();
                    end
                end
                if (out_valid && out_ready) begin
                    outs++;
                    if (out_last) lasts++;
                    got.push_back(out_data);
                    gotl.push_back(out_last);
                    gotc.push_back(cyc);
                    if (ed.size() == 0) chk("unexpected output", 1, 0);
                    else begin
                        chk("out data", out_data, ed.pop_front());
                        chk("out last", out_last, el.pop_front());
                    end
                end
            end
        end

        task automatic push(input logic [DW-1:0] d, input logic t);
            int  w = 0;
            logic hs;
            in_valid = 1'b1;
            in_data = d;
            in_t = t;
            do begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
                w++;
            end while (!hs && w < 1000);
            if (!hs) chk("push timeout", 0, 1);
            in_valid = 1'b0;
        endtask

        task automatic drain();
            int c = 0;
            while ((ed.size() != 0 || out_valid) && c < 3000) begin
                @(posedge clk);
                #1;
                c++;
            end
            if (c == 3000) chk("drain timeout", 0, 1);
        endtask

        task automatic clear();
            got.delete();
            gotl.delete();
            gotc.delete();
            lasts = 0;
        endtask

        if (g == 0) begin : dir
            initial begin
                int   bi, bo, t0;
                bit   seen;
                rst = 1'b1; in_valid = 1'b0; in_data = '0; in_t = 1'b0; out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("reset out_valid", out_valid, 0);
                chk("reset out_data", out_data, 0);
                chk("reset out_last", out_last, 0);
                chk("in_ready in rst", in_ready, 0);
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("in_ready after rst", in_ready, 1);
                @(posedge clk); #1;
                // transposed block 0..63
                clear();
                for (int k = 0; k < 64; k++) push(DW'(k), 1'b1);
                @(negedge clk);
                chk("latency low", out_valid, 0);
                @(negedge clk);
                chk("latency high", out_valid, 1);
                chk("first sample", out_data, 0);
                @(posedge clk); #1;
                drain();
                chk("t1 count", got.size(), 64);
                chk("t1 [1]", got[1], 8);
                chk("t1 [8]", got[8], 1);
                chk("t1 [62]", got[62], 55);
                chk("t1 [63]", got[63], 63);
                chk("t1 last flag", gotl[63], 1);
                chk("t1 lasts", lasts, 1);
                // passthrough block followed by transposed block
                clear();
                for (int k = 0; k < 64; k++) push(DW'(100 + k), 1'b0);
                for (int k = 0; k < 64; k++) push(DW'(200 + k), 1'b1);
                drain();
                chk("t2 count", got.size(), 128);
                chk("t2 [5]", got[5], 105);
                chk("t2 [63]", got[63], 163);
                chk("t2 [65]", got[65], 208);
                chk("t2 [127]", got[127], 263);
                chk("t2 lasts", lasts, 2);
                // back-pressure: three blocks against a stalled sink
                clear();
                out_ready = 1'b0;
                bi = ins;
                bo = outs;
                fork
                    for (int b = 0; b < 3; b++)
                        for (int k = 0; k < 64; k++) push(DW'(300 + b * 64 + k), b == 1);
                    begin
                        repeat (200) @(posedge clk);
                        #1;
                        chk("bp accepted", ins - bi, 128);
                        chk("bp in_ready", in_ready, 0);
                        chk("bp no output", outs - bo, 0);
                        out_ready = 1'b1;
                        seen = 0;
                        for (int c = 0; c < 300 && !seen; c++) begin
                            @(posedge clk);
                            #1;
                            if (ins - bi >= 129) begin
                                seen = 1;
                                chk("bp drained before third", outs - bo, 64);
                            end
                        end
                        if (!seen) chk("bp third accepted", 0, 1);
                    end
                join
                drain();
                chk("bp count", got.size(), 192);
                chk("bp [0]", got[0], 300);
                chk("bp [63]", got[63], 363);
                chk("bp [64]", got[64], 364);
                chk("bp [65]", got[65], 372);
                chk("bp [128]", got[128], 428);
                chk("bp [191]", got[191], 491);
                // streaming four blocks back to back
                clear();
                t0 = cyc;
                for (int b = 0; b < 4; b++)
                    for (int k = 0; k < 64; k++) push(DW'(500 + b * 64 + k), 1'b1);
                chk("stream input cycles", cyc - t0, 256);
                drain();
                chk("stream count", got.size(), 256);
                chk("stream latency", gotc[0] - t0, 65);
                chk("stream no bubbles", gotc[255] - gotc[0], 255);
                chk("stream [1]", got[1], 508);
                chk("stream [72]", got[72], 565);
                chk("stream [255]", got[255], 755);
                // reset in the middle of a block
                for (int k = 0; k < 30; k++) push(DW'(900 + k), 1'b1);
                rst = 1'b1;
                @(negedge clk);
                chk("mid rst out_valid", out_valid, 0);
                chk("mid rst in_ready", in_ready, 0);
                @(posedge clk); #1 rst = 1'b0;
                clear();
                for (int k = 0; k < 64; k++) push(DW'(k), 1'b1);
                drain();
                chk("rst count", got.size(), 64);
                chk("rst [0]", got[0], 0);
                chk("rst [1]", got[1], 8);
                chk("rst [63]", got[63], 63);
                chk("rst last flag", gotl[63], 1);
                fin = 1;
            end
        end else begin : rnd
            initial begin
                logic t;
                rst = 1'b1; in_valid = 1'b0; in_data = '0; in_t = 1'b0; out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                fork
                    begin
                        for (int b = 0; b < NB; b++) begin
                            t = 1'($urandom_range(0, 1));
                            for (int k = 0; k < D; k++) begin
                                if ($urandom_range(0, 3) == 0) begin
                                    @(posedge clk);
                                    #1;
                                end
                                push(DW'($urandom), t);
                            end
                        end
                        stop = 1;
                    end
                    begin
                        while (!stop) begin
                            out_ready = $urandom_range(0, 3) != 0;
                            @(posedge clk);
                            #1;
                        end
                        out_ready = 1'b1;
                    end
                join
                drain();
                chk("rand inputs", ins, NB * D);
                chk("rand blocks out", lasts, NB);
                fin = 1;
            end
        end
    end

    initial begin
        wait (gen[0].fin && gen[1].fin && gen[2].fin);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        miscompares++;
        $display("FAIL watchdog: finished %0d%0d%0d expected 111", gen[0].fin, gen[1].fin, gen[2].fin);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
